// File: rtl/vx_tcu_pkg.sv
// Shared definitions for the tensor-core FEDP K-loop sequencer: states, format codes
// and the FEDP pipeline-depth helper used by parents and benches.
package vx_tcu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] FMT_FP16 = 3'd1;
  localparam logic [2:0] FMT_BF16 = 3'd2;
  localparam logic [2:0] FMT_TF32 = 3'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Multiplier stages, alignment, adder tree of depth clog2(2N), normalise/round.
  function automatic int fedp_latency(input int n);
    return 3 + 1 + $clog2(2 * n) * 3 + 3;
  endfunction

endpackage

// File: rtl/vx_tcu_seq_rsp_buf.sv
// One-entry valid/ready holding register for the sequencer's final accumulator.
// Contents stay stable from load until the consumer takes them.
module vx_tcu_seq_rsp_buf
  import vx_tcu_pkg::*;
#(
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] load_d,
  input  logic [TAGW-1:0] load_tag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_d,
  output logic [TAGW-1:0] rsp_tag
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] d_q, d_d;
  logic [TAGW-1:0] tag_q, tag_d;

  always_comb begin
    valid_d = valid_q;
    d_d     = d_q;
    tag_d   = tag_q;
    if (valid_q && rsp_ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      d_d     = load_d;
      tag_d   = load_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      d_q     <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      d_q     <= d_d;
      tag_q   <= tag_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_d     = d_q;
  assign rsp_tag   = tag_q;

endmodule

// File: rtl/vx_tcu_fedp_seq.sv
// K-loop sequencer feeding the FEDP one operand step at a time and chaining D back into C.
// Optional performance counters are enabled with the VX_TCU_SEQ_PERF_EN macro.
module vx_tcu_fedp_seq
  import vx_tcu_pkg::*;
#(
  parameter int N            = 2,
  parameter int FEDP_LATENCY = 13,
  parameter int STEPW        = 8,
  parameter int TAGW         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_fmt_s,
  input  logic [2:0]        req_fmt_d,
  input  logic [STEPW-1:0]  req_steps,
  input  logic [XLEN-1:0]   req_c,
  input  logic [TAGW-1:0]   req_tag,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [N*XLEN-1:0] op_a,
  input  logic [N*XLEN-1:0] op_b,
  output logic              fedp_enable,
  output logic [2:0]        fedp_fmt_s,
  output logic [2:0]        fedp_fmt_d,
  output logic [N*XLEN-1:0] fedp_a,
  output logic [N*XLEN-1:0] fedp_b,
  output logic [XLEN-1:0]   fedp_c,
  input  logic [XLEN-1:0]   fedp_d,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_d,
  output logic [TAGW-1:0]   rsp_tag,
  output logic              busy
`ifdef VX_TCU_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_op_stall_cycles,
  output logic [31:0]       perf_rsp_stall_cycles
`endif
);

  localparam int WAITW = (FEDP_LATENCY > 1) ? $clog2(FEDP_LATENCY) : 1;
  localparam logic [WAITW-1:0] WAIT_INIT = WAITW'((FEDP_LATENCY > 0) ? FEDP_LATENCY - 1 : 0);

  seq_state_e       state_q, state_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [STEPW-1:0] steps_q, steps_d;
  logic [WAITW-1:0] wait_q, wait_d;
  logic [TAGW-1:0]  tag_q, tag_d;
  logic [2:0]       fmt_s_q, fmt_s_d;
  logic [2:0]       fmt_d_q, fmt_d_d;
  logic             rsp_load;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    steps_d     = steps_q;
    wait_d      = wait_q;
    tag_d       = tag_q;
    fmt_s_d     = fmt_s_q;
    fmt_d_d     = fmt_d_q;
    req_ready   = 1'b0;
    op_ready    = 1'b0;
    fedp_enable = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          fmt_s_d = req_fmt_s;
          fmt_d_d = req_fmt_d;
          acc_d   = req_c;
          steps_d = req_steps;
          tag_d   = req_tag;
          state_d = (req_steps == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        op_ready    = 1'b1;
        fedp_enable = 1'b1;
        if (op_valid) begin
          if (FEDP_LATENCY > 0) begin
            wait_d  = WAIT_INIT;
            state_d = WAIT;
          end else begin
            // Combinational FEDP: the result is already on fedp_d this cycle.
            acc_d   = fedp_d;
            steps_d = steps_q - STEPW'(1);
            state_d = (steps_q == STEPW'(1)) ? DONE : ISSUE;
          end
        end
      end
      WAIT: begin
        fedp_enable = 1'b1;
        if (wait_q != '0) begin
          wait_d = wait_q - WAITW'(1);
        end else begin
          acc_d   = fedp_d;
          steps_d = steps_q - STEPW'(1);
          state_d = (steps_q == STEPW'(1)) ? DONE : ISSUE;
        end
      end
      DONE: begin
        if (rsp_valid && rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The response register is loaded exactly once, on entry to DONE.
  assign rsp_load = (state_d == DONE) && (state_q != DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      steps_q <= '0;
      wait_q  <= '0;
      tag_q   <= '0;
      fmt_s_q <= '0;
      fmt_d_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      steps_q <= steps_d;
      wait_q  <= wait_d;
      tag_q   <= tag_d;
      fmt_s_q <= fmt_s_d;
      fmt_d_q <= fmt_d_d;
    end
  end

  assign fedp_a     = op_a;
  assign fedp_b     = op_b;
  assign fedp_c     = acc_q;
  assign fedp_fmt_s = fmt_s_q;
  assign fedp_fmt_d = fmt_d_q;
  assign busy       = (state_q != IDLE);

  vx_tcu_seq_rsp_buf #(
    .TAGW(TAGW)
  ) u_rsp_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (rsp_load),
    .load_d   (acc_d),
    .load_tag (tag_d),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_d    (rsp_d),
    .rsp_tag  (rsp_tag)
  );

`ifdef VX_TCU_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [31:0] perf_op_q, perf_op_d;
  logic [31:0] perf_rsp_q, perf_rsp_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    perf_busy_d = sat_inc(perf_busy_q, state_q != IDLE);
    perf_op_d   = sat_inc(perf_op_q, (state_q == ISSUE) && !op_valid);
    perf_rsp_d  = sat_inc(perf_rsp_q, (state_q == DONE) && !rsp_ready);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_busy_q <= '0;
      perf_op_q   <= '0;
      perf_rsp_q  <= '0;
    end else begin
      perf_busy_q <= perf_busy_d;
      perf_op_q   <= perf_op_d;
      perf_rsp_q  <= perf_rsp_d;
    end
  end

  assign perf_busy_cycles      = perf_busy_q;
  assign perf_op_stall_cycles  = perf_op_q;
  assign perf_rsp_stall_cycles = perf_rsp_q;
`endif

endmodule

// File: tb/tb_vx_tcu_fedp_seq.sv
// Scoreboard bench for vx_tcu_fedp_seq driving a behavioural FEDP pipeline model;
// expected results are hand-computed FP32 constants queued at request time.
module tb_vx_tcu_fedp_seq;
  import vx_tcu_pkg::*;

  localparam int N     = 2;
  localparam int LAT   = fedp_latency(N);
  localparam int STEPW = 8;
  localparam int TAGW  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_fmt_s, req_fmt_d;
  logic [STEPW-1:0]  req_steps;
  logic [XLEN-1:0]   req_c;
  logic [TAGW-1:0]   req_tag;
  logic              op_valid, op_ready;
  logic [N*XLEN-1:0] op_a, op_b;
  logic              fedp_enable;
  logic [2:0]        fedp_fmt_s, fedp_fmt_d;
  logic [N*XLEN-1:0] fedp_a, fedp_b;
  logic [XLEN-1:0]   fedp_c, fedp_d;
  logic              rsp_valid, rsp_ready;
  logic [XLEN-1:0]   rsp_d;
  logic [TAGW-1:0]   rsp_tag;
  logic              busy;
`ifdef VX_TCU_SEQ_PERF_EN
  logic [31:0] perf_busy_cycles, perf_op_stall_cycles, perf_rsp_stall_cycles;
`endif

  vx_tcu_fedp_seq #(
    .N(N), .FEDP_LATENCY(LAT), .STEPW(STEPW), .TAGW(TAGW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt_s(req_fmt_s),
    .req_fmt_d(req_fmt_d), .req_steps(req_steps), .req_c(req_c), .req_tag(req_tag),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .fedp_enable(fedp_enable), .fedp_fmt_s(fedp_fmt_s), .fedp_fmt_d(fedp_fmt_d),
    .fedp_a(fedp_a), .fedp_b(fedp_b), .fedp_c(fedp_c), .fedp_d(fedp_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d(rsp_d), .rsp_tag(rsp_tag),
    .busy(busy)
`ifdef VX_TCU_SEQ_PERF_EN
    , .perf_busy_cycles(perf_busy_cycles), .perf_op_stall_cycles(perf_op_stall_cycles),
    .perf_rsp_stall_cycles(perf_rsp_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural FEDP ----------------
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f32r(input logic [31:0] x);
    real v;
    if (x[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
    return x[31] ? -v : v;
  endfunction

  function automatic real h2r(input logic [2:0] fmt, input logic [15:0] h);
    real v;
    if (fmt == FMT_BF16) return f32r({h, 16'h0000});
    if (h[14:10] == 5'd0) return 0.0;
    v = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f32(input real r_in);
    real r = r_in;
    logic s = 1'b0;
    int e = 0;
    int m;
    if (r == 0.0) return 32'h0;
    if (r < 0.0) begin s = 1'b1; r = -r; end
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0) begin r = r * 2.0; e--; end
    m = $rtoi((r - 1.0) * 8388608.0);
    return {s, 8'(e + 127), 23'(m)};
  endfunction

  function automatic logic [31:0] fedp_model(input logic [2:0] fmt, input logic [N*XLEN-1:0] a,
                                             input logic [N*XLEN-1:0] b, input logic [31:0] c);
    real sum = f32r(c);
    logic [31:0] aw, bw;
    for (int w = 0; w < N; w++) begin
      aw = a[w*32 +: 32];
      bw = b[w*32 +: 32];
      if (fmt == FMT_TF32) sum = sum + f32r(aw) * f32r(bw);
      else for (int h = 0; h < 2; h++) sum = sum + h2r(fmt, aw[h*16 +: 16]) * h2r(fmt, bw[h*16 +: 16]);
    end
    return r2f32(sum);
  endfunction

  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    if (fedp_enable) begin
      pipe[0] <= fedp_model(fedp_fmt_s, fedp_a, fedp_b, fedp_c);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign fedp_d = pipe[LAT-1];

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0]     d;
    logic [TAGW-1:0] tag;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int op_ready_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  logic            prev_hold = 1'b0;
  logic [31:0]     prev_d;
  logic [TAGW-1:0] prev_tag;

  always @(negedge clk) begin
    if (reset && prev_hold) begin
      chk("rsp_hold_valid", rsp_valid, 1'b1);
      chk("rsp_hold_d", rsp_d, prev_d);
      chk("rsp_hold_tag", rsp_tag, prev_tag);
    end
    if (op_ready) op_ready_cnt <= op_ready_cnt + 1;
    if (reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rsp_unexpected: got d=%0h tag=%0h, required no response", rsp_d, rsp_tag);
      end else begin
        chk("rsp_d", rsp_d, exp_q[0].d);
        chk("rsp_tag", rsp_tag, exp_q[0].tag);
        void'(exp_q.pop_front());
      end
    end
    prev_hold <= reset && rsp_valid && !rsp_ready;
    prev_d    <= rsp_d;
    prev_tag  <= rsp_tag;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_req(input logic [2:0] fmt, input int steps, input logic [31:0] c,
                          input logic [TAGW-1:0] tag, input logic [31:0] exp_d, output int acc);
    exp_q.push_back({exp_d, tag});
    req_valid = 1'b1; req_fmt_s = fmt; req_fmt_d = fmt ^ 3'd4;
    req_steps = STEPW'(steps); req_c = c; req_tag = tag;
    acc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin acc = cyc; break; end
    end
    if (acc < 0) timeout("req_accept");
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_op(input logic [N*XLEN-1:0] a, input logic [N*XLEN-1:0] b,
                         input logic [2:0] fmt, input int gap, output int acc);
    repeat (gap) begin @(posedge clk); #1; end
    op_valid = 1'b1; op_a = a; op_b = b;
    acc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (op_ready) begin acc = cyc; break; end
    end
    if (acc < 0) timeout("op_accept");
    else begin
      chk("op_fedp_enable", fedp_enable, 1'b1);
      chk("op_fedp_fmt_s", fedp_fmt_s, fmt);
      chk("op_fedp_fmt_d", fedp_fmt_d, fmt ^ 3'd4);
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_rsp_valid(output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      if (rsp_valid) begin t = cyc; break; end
      @(negedge clk);
    end
    if (t < 0) timeout("rsp_valid");
  endtask

  task automatic drain(input string name);
    int ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (ok == 0) timeout(name);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_d"}, rsp_d, 32'h0);
    chk({tag, "_rsp_tag"}, rsp_tag, 4'h0);
    chk({tag, "_fedp_enable"}, fedp_enable, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_op_ready"}, op_ready, 1'b0);
  endtask

  localparam logic [N*XLEN-1:0] FP16_ONE   = {N{32'h3C003C00}};
  localparam logic [N*XLEN-1:0] FP16_TWO   = {N{32'h40004000}};
  localparam logic [N*XLEN-1:0] FP16_THREE = {N{32'h42004200}};
  localparam logic [N*XLEN-1:0] BF16_ONE   = {N{32'h3F803F80}};
  localparam logic [N*XLEN-1:0] BF16_TWO   = {N{32'h40004000}};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tb, tr, cnt0, dummy;
    reset = 1'b0; req_valid = 1'b0; req_fmt_s = '0; req_fmt_d = '0; req_steps = '0;
    req_c = '0; req_tag = '0; op_valid = 1'b0; op_a = '0; op_b = '0; rsp_ready = 1'b1;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single FP16 job, 3 steps of 4 x (1.0*2.0): 24.0, 42 cycles from first operand accept
    send_req(FMT_FP16, 3, 32'h0, 4'h3, 32'h41C00000, dummy);
    send_op(FP16_ONE, FP16_TWO, FMT_FP16, 0, ta);
    send_op(FP16_ONE, FP16_TWO, FMT_FP16, 0, tb);
    chk("t1_step_spacing", tb - ta, LAT + 1);
    send_op(FP16_ONE, FP16_TWO, FMT_FP16, 0, dummy);
    wait_rsp_valid(tr);
    chk("t1_latency", tr - ta, 42);
    drain("t1_drain");

    // Zero-step job returns C unchanged one cycle after accept, no operand pulled
    cnt0 = op_ready_cnt;
    send_req(FMT_FP16, 0, 32'h3F800000, 4'h1, 32'h3F800000, ta);
    wait_rsp_valid(tr);
    chk("t2_rsp_delay", tr - ta, 1);
    drain("t2_drain");
    chk("t2_no_op_ready", op_ready_cnt - cnt0, 0);

    // Operand gaps and a 10-cycle response stall: 1 + 2*(4*2*3) = 49.0
    rsp_ready = 1'b0;
    send_req(FMT_FP16, 2, 32'h3F800000, 4'hA, 32'h42440000, dummy);
    send_op(FP16_TWO, FP16_THREE, FMT_FP16, 5, dummy);
    send_op(FP16_TWO, FP16_THREE, FMT_FP16, 5, dummy);
    wait_rsp_valid(tr);
    chk("t3_req_ready_hold", req_ready, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t3_req_ready_hold", req_ready, 1'b0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain("t3_drain");

    // Reset during the WAIT of step 2 discards the job
    send_req(FMT_FP16, 3, 32'h0, 4'h7, 32'h41C00000, dummy);
    send_op(FP16_ONE, FP16_TWO, FMT_FP16, 0, dummy);
    send_op(FP16_ONE, FP16_TWO, FMT_FP16, 0, dummy);
    repeat (3) begin @(posedge clk); #1; end
    chk("t4_in_wait_busy", busy, 1'b1);
    reset = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check_reset_outputs("t4_rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    send_req(FMT_BF16, 1, 32'h40000000, 4'h2, 32'h40C00000, dummy);
    send_op(BF16_ONE, BF16_ONE, FMT_BF16, 0, dummy);
    drain("t4_drain");

    // Back-to-back jobs with operands offered early for the second job
    fork
      begin
        int d1, d2;
        send_req(FMT_FP16, 1, 32'h0, 4'h5, 32'h40800000, d1);
        send_req(FMT_BF16, 2, 32'h3F800000, 4'h9, 32'h41880000, d2);
      end
      begin
        int e1, e2, e3;
        send_op(FP16_ONE, FP16_ONE, FMT_FP16, 0, e1);
        send_op(BF16_TWO, BF16_ONE, FMT_BF16, 0, e2);
        send_op(BF16_TWO, BF16_ONE, FMT_BF16, 0, e3);
      end
    join
    drain("t5_drain");

`ifdef VX_TCU_SEQ_PERF_EN
    reset = 1'b0;
    #1;
    chk("t6_perf_busy_rst", perf_busy_cycles, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send_req(FMT_FP16, 2, 32'h0, 4'hC, 32'h41000000, dummy);
    send_op(FP16_ONE, FP16_ONE, FMT_FP16, 4, dummy);
    send_op(FP16_ONE, FP16_ONE, FMT_FP16, 0, dummy);
    wait_rsp_valid(tr);
    repeat (3) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain("t6_drain");
    chk("t6_perf_op_stall", perf_op_stall_cycles, 32'd4);
    chk("t6_perf_rsp_stall", perf_rsp_stall_cycles, 32'd3);
    chk("t6_perf_busy", perf_busy_cycles, 32'd36);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("final_idle", busy, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vx_tcu_fedp_seq.md
Name: vx_tcu_fedp_seq

Overview:
Upstream K-loop sequencer for the tensor-core dot-product unit (FEDP).
- Accepts one dot-product job (format, initial accumulator C, step count, tag).
- Pulls one operand step (A row, B column) per K iteration from an operand stream.
- Drives the FEDP, waits its fixed pipeline latency, and feeds each D result back as the next step's C.
- Returns the final accumulator through a buffered valid/ready response port.

Parameters:
N, 2, XLEN words per operand row/column; must match the FEDP's N.
FEDP_LATENCY, 13, FEDP pipeline depth in cycles; 0 means the FEDP is combinational.
STEPW, 8, width of the step-count field.
TAGW, 4, width of the opaque job tag.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low reset.
req_valid  in  1  job request valid.
req_ready  out  1  job request accepted.
req_fmt_s  in  3  source format: 1=FP16, 2=BF16, 3=TF32.
req_fmt_d  in  3  destination format, passed through unchanged.
req_steps  in  STEPW  number of K steps.
req_c  in  XLEN  initial accumulator (FP32).
req_tag  in  TAGW  opaque job ID.
op_valid  in  1  operand step valid.
op_ready  out  1  operand step accepted.
op_a  in  N*XLEN  A row for this step.
op_b  in  N*XLEN  B column for this step.
fedp_enable  out  1  FEDP pipeline enable.
fedp_fmt_s  out  3  to FEDP fmt_s.
fedp_fmt_d  out  3  to FEDP fmt_d.
fedp_a  out  N*XLEN  to FEDP a_row.
fedp_b  out  N*XLEN  to FEDP b_col.
fedp_c  out  XLEN  to FEDP c_val.
fedp_d  in  XLEN  from FEDP d_val.
rsp_valid  out  1  result valid.
rsp_ready  in  1  result accepted.
rsp_d  out  XLEN  final accumulator.
rsp_tag  out  TAGW  tag of the completed job.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; acc, steps_left, wait_cnt, tag and formats cleared to 0.
  - Outputs at reset: rsp_valid=0, rsp_d=0, rsp_tag=0, fedp_enable=0, busy=0, op_ready=0, req_ready=1.
  - A reset mid-job discards the job completely; no partial response is ever produced.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture fmt_s, fmt_d, c→acc, steps→steps_left, tag.
  - If req_steps==0, go to DONE (response is req_c unchanged); otherwise go to ISSUE.
- ISSUE:
  - op_ready=1, fedp_enable=1.
  - fedp_a/fedp_b are combinationally op_a/op_b; fedp_c=acc; fedp_fmt_* are the captured formats.
  - On op handshake with FEDP_LATENCY>0: wait_cnt←FEDP_LATENCY-1, go to WAIT.
  - On op handshake with FEDP_LATENCY==0: acc←fedp_d same cycle, steps_left--, stay in ISSUE or go to DONE.
  - Without op_valid, remain in ISSUE; fedp_enable stays 1, and whatever the FEDP outputs is ignored.
- WAIT:
  - op_ready=0, fedp_enable=1, fedp_c holds acc.
  - While wait_cnt≠0, decrement it.
  - When wait_cnt==0: acc←fedp_d, steps_left--; if the new value is 0 go to DONE, else go to ISSUE.
  - Timing: an operand accepted in cycle t produces its result captured in cycle t+FEDP_LATENCY; the next issue is no earlier than t+FEDP_LATENCY+1.
  - Minimum job time: steps*(FEDP_LATENCY+1) cycles plus one IDLE cycle and one DONE cycle.
- DONE:
  - rsp_valid=1, rsp_d=acc, rsp_tag=tag.
  - On rsp_ready, go to IDLE; req_ready is not asserted in DONE, so a new job is accepted no earlier than the following cycle.
  - rsp_* is held stable until the handshake.
- fedp_enable=0 in IDLE and DONE; FEDP output in those states is don't-care.
- Only one job is in flight at a time; there is no overlap between jobs.
- steps=2^STEPW-1 must complete without wrap-around; steps_left never underflows.
- All arithmetic is performed in the FEDP; this block only moves data.

Optional Feature:
VX_TCU_SEQ_PERF_EN:
- When defined, adds 32-bit outputs perf_busy_cycles, perf_op_stall_cycles and perf_rsp_stall_cycles.
  - perf_busy_cycles increments every cycle state≠IDLE.
  - perf_op_stall_cycles increments in ISSUE with op_valid=0.
  - perf_rsp_stall_cycles increments in DONE with rsp_ready=0.
- Counters saturate at all-ones and clear on reset.
- When not defined, these ports and counters do not exist and the rest of the behaviour is identical.

Decomposition:
- Shared package (vx_tcu_pkg) holds:
  - state enum;
  - format codes FMT_FP16=1, FMT_BF16=2, FMT_TF32=3;
  - a function computing FEDP latency from N (3+1+clog2(2N)*3+3), used by the bench and by instantiating parents.
- One natural sub-module: vx_tcu_seq_rsp_buf, a one-entry valid/ready response holding register.

Test Plan:
- Single job, bench with a real FEDP: N=2, FP16; every op_a half 0x3C00 (1.0), every op_b half 0x4000 (2.0); steps=3, c=0 → rsp_d=0x41C00000 (24.0) with the job's tag, exactly 3*14 cycles after the first op accept.
- steps=0, c=0x3F800000 → rsp_valid one cycle after request accept, rsp_d=0x3F800000, no op_ready pulses.
- Backpressure: op_valid gaps of 5 cycles between steps, then rsp_ready held low 10 cycles → result unchanged, rsp_* stable while rsp_valid=1, req_ready=0 during the hold.
- Reset asserted in WAIT of step 2 → all outputs return to reset values immediately; next job (BF16, steps=1, a=b=0x3F80 halves, c=0x40000000) → rsp_d=0x40C00000 (6.0).
- Back-to-back jobs with tags 5 and 9, rsp_ready=1 → responses in order with the correct tags, no operand leaks between jobs.
- VX_TCU_SEQ_PERF_EN, steps=2, op stall 4 cycles, rsp stall 3 cycles → perf_op_stall_cycles=4, perf_rsp_stall_cycles=3.
